// File: rtl/crc_pkg.sv
// Shared CCITT CRC-16 definitions (poly 0x1021, MSB-first, non-reflected)
// and the frame controller state encoding.
package crc_pkg;

  localparam logic [15:0] CRC_POLY   = 16'h1021;
  localparam logic [15:0] CRC_XOROUT = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_CRC_HI = 2'd2,
    ST_CRC_LO = 2'd3
  } state_t;

  // Byte update, data bit 7 enters first; unrolls into the usual XOR tree.
  function automatic logic [15:0] crc_ccitt_step(input logic [15:0] crc,
                                                 input logic [7:0]  data);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ data[i];
      c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc_ccitt_byte_step.sv
// Purely combinational CCITT CRC-16 byte update wrapping crc_pkg::crc_ccitt_step.
module crc_ccitt_byte_step
  import crc_pkg::*;
(
  input  logic [15:0] crc,
  input  logic [7:0]  data,
  output logic [15:0] crc_next
);

  assign crc_next = crc_ccitt_step(crc, data);

endmodule

// File: rtl/crc_frame_tx_ctrl.sv
// Transmit frame controller: forwards payload bytes and appends CRC-16 (high byte first).
// Optional final complement of the appended CRC under macro CRC_FRAME_XOROUT_EN.
module crc_frame_tx_ctrl
  import crc_pkg::*;
#(
  parameter logic [15:0] INIT_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [7:0]  s_data,
  input  logic        s_last,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [7:0]  m_data,
  output logic        m_last,
  output logic        frame_done,
  output logic [15:0] crc_result
);

  state_t      state;
  state_t      state_next;
  logic [15:0] crc_acc;
  logic [15:0] crc_step;
  logic [15:0] crc_app;
  logic        out_free;
  logic        accept;
  logic        load_hi;
  logic        load_lo;

  crc_ccitt_byte_step u_step (
    .crc      (crc_acc),
    .data     (s_data),
    .crc_next (crc_step)
  );

`ifdef CRC_FRAME_XOROUT_EN
  assign crc_app = crc_acc ^ CRC_XOROUT;
`else
  assign crc_app = crc_acc;
`endif

  // Output slot is free when empty or draining this cycle; input only in IDLE/DATA.
  always_comb begin
    out_free = !m_valid || m_ready;
    s_ready  = !reset && out_free && ((state == ST_IDLE) || (state == ST_DATA));
    accept   = s_valid && s_ready;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_hi    = 1'b0;
    load_lo    = 1'b0;
    unique case (state)
      ST_IDLE, ST_DATA: begin
        if (accept) begin
          state_next = s_last ? ST_CRC_HI : ST_DATA;
        end
      end
      ST_CRC_HI: begin
        if (out_free) begin
          load_hi    = 1'b1;
          state_next = ST_CRC_LO;
        end
      end
      ST_CRC_LO: begin
        if (out_free) begin
          load_lo    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Registered output byte stage and CRC accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      crc_acc    <= INIT_VALUE;
      m_valid    <= 1'b0;
      m_data     <= 8'h00;
      m_last     <= 1'b0;
      frame_done <= 1'b0;
      crc_result <= 16'h0000;
    end else begin
      frame_done <= m_valid && m_ready && m_last;
      if (accept) begin
        m_data  <= s_data;
        m_valid <= 1'b1;
        m_last  <= 1'b0;
        crc_acc <= crc_step;
      end else if (load_hi) begin
        m_data  <= crc_app[15:8];
        m_valid <= 1'b1;
        m_last  <= 1'b0;
      end else if (load_lo) begin
        m_data     <= crc_app[7:0];
        m_valid    <= 1'b1;
        m_last     <= 1'b1;
        crc_result <= crc_app;
        crc_acc    <= INIT_VALUE;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_tx_ctrl.sv
// Scoreboard bench for crc_frame_tx_ctrl; two instances (INIT 0x0000 and 0xFFFF)
// run in lockstep on shared stimulus. Honours CRC_FRAME_XOROUT_EN like the RTL.
module tb_crc_frame_tx_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_valid;
  logic [7:0]  s_data;
  logic        s_last;
  logic        m_ready;
  logic        s_ready0, m_valid0, m_last0, frame_done0;
  logic        s_ready1, m_valid1, m_last1, frame_done1;
  logic [7:0]  m_data0, m_data1;
  logic [15:0] crc_result0, crc_result1;

`ifdef CRC_FRAME_XOROUT_EN
  localparam logic [15:0] KV0 = 16'hCE3C;
  localparam logic [15:0] KV1 = 16'hD64E;
  localparam logic [15:0] XO  = 16'hFFFF;
`else
  localparam logic [15:0] KV0 = 16'h31C3;
  localparam logic [15:0] KV1 = 16'h29B1;
  localparam logic [15:0] XO  = 16'h0000;
`endif

  always #5 clk = ~clk;

  crc_frame_tx_ctrl #(.INIT_VALUE(16'h0000)) dut0 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready0),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid0), .m_ready(m_ready),
    .m_data(m_data0), .m_last(m_last0), .frame_done(frame_done0),
    .crc_result(crc_result0)
  );

  crc_frame_tx_ctrl #(.INIT_VALUE(16'hFFFF)) dut1 (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready1),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid1), .m_ready(m_ready),
    .m_data(m_data1), .m_last(m_last1), .frame_done(frame_done1),
    .crc_result(crc_result1)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  int          done_cnt = 0;
  int          stall_err = 0;
  bit          bp_en = 1'b0;
  logic [17:0] exp_q[$];
  logic [17:0] obs_q[$];
  logic [15:0] last_crc0, last_crc1;

  function automatic logic [15:0] ref_step(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else              r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Monitor: records output handshakes, frame_done pulses and stall stability.
  initial begin
    logic       stall_pend;
    logic [9:0] stall_val;
    stall_pend = 1'b0;
    stall_val  = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_pend = 1'b0;
      end else begin
        if (m_valid0 && m_ready) obs_q.push_back({m_last1, m_data1, m_last0, m_data0});
        if (frame_done0) done_cnt++;
        if (stall_pend && ({m_valid0, m_last0, m_data0} !== stall_val)) stall_err++;
        stall_pend = m_valid0 && !m_ready;
        stall_val  = {m_valid0, m_last0, m_data0};
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic send_frame(input logic [7:0] b[$]);
    logic [15:0] c0, c1;
    int t;
    c0 = 16'h0000;
    c1 = 16'hFFFF;
    foreach (b[i]) begin
      s_valid = 1'b1;
      s_data  = b[i];
      s_last  = (i == b.size() - 1);
      t = 0;
      @(negedge clk);
      while (s_ready0 !== 1'b1 && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (t >= 500) begin
        n_checks++;
        n_fail++;
        $display("FAIL send_timeout: byte %0d s_ready=%b, required 1", i, s_ready0);
      end
      exp_q.push_back({1'b0, b[i], 1'b0, b[i]});
      c0 = ref_step(c0, b[i]);
      c1 = ref_step(c1, b[i]);
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    c0 = c0 ^ XO;
    c1 = c1 ^ XO;
    exp_q.push_back({1'b0, c1[15:8], 1'b0, c0[15:8]});
    exp_q.push_back({1'b1, c1[7:0],  1'b1, c0[7:0]});
    last_crc0 = c0;
    last_crc1 = c1;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (obs_q.size() < exp_q.size() && t < 3000) begin
      @(posedge clk);
      t++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    n_checks++; if (s_ready0 !== 1'b0) begin n_fail++; $display("FAIL rst_s_ready: got %b, required 0", s_ready0); end
    n_checks++; if (m_valid0 !== 1'b0) begin n_fail++; $display("FAIL rst_m_valid: got %b, required 0", m_valid0); end
    n_checks++; if (m_data0 !== 8'h00) begin n_fail++; $display("FAIL rst_m_data: got %h, required 00", m_data0); end
    n_checks++; if (m_last0 !== 1'b0) begin n_fail++; $display("FAIL rst_m_last: got %b, required 0", m_last0); end
    n_checks++; if (frame_done0 !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b, required 0", frame_done0); end
    n_checks++; if (crc_result1 !== 16'h0000) begin n_fail++; $display("FAIL rst_crc_result: got %h, required 0000", crc_result1); end
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_known_vector();
    logic [7:0]  fr[$];
    logic [17:0] e, o;
    int d0;
    d0 = done_cnt;
    m_ready = 1'b1;
    for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
    send_frame(fr);
    wait_drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL kv_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL kv_beat%0d: got %h, required %h", k, o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (crc_result0 !== KV0) begin n_fail++; $display("FAIL kv_crc_init0: got %h, required %h", crc_result0, KV0); end
    n_checks++; if (crc_result1 !== KV1) begin n_fail++; $display("FAIL kv_crc_initF: got %h, required %h", crc_result1, KV1); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL kv_frame_done: got %0d pulses, required 1", done_cnt - d0); end
  endtask

  task automatic test_single_byte();
    logic [7:0]  fr[$];
    logic [17:0] e, o;
    m_ready = 1'b1;
    fr.push_back(8'h00);
    send_frame(fr);
    @(negedge clk);
    n_checks++; if (s_ready0 !== 1'b0) begin n_fail++; $display("FAIL sb_goes_crc_hi: s_ready got %b, required 0", s_ready0); end
    wait_drain();
    n_checks++;
    if (obs_q.size() !== 3) begin n_fail++; $display("FAIL sb_count: got %0d beats, required 3", obs_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL sb_beat%0d: got %h, required %h", k, o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (crc_result0 !== XO) begin n_fail++; $display("FAIL sb_crc: got %h, required %h", crc_result0, XO); end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  fa[$], fb[$];
    logic [17:0] e, o;
    logic        sr[7], ml[7], fd[7];
    logic [5:0]  exp_sr;
    int d0;
    exp_sr = 6'b100111;
    d0 = done_cnt;
    m_ready = 1'b1;
    fa.push_back(8'hA1); fa.push_back(8'h5E); fa.push_back(8'h07);
    fb.push_back(8'hC4); fb.push_back(8'h19);
    @(posedge clk);
    #1;
    fork
      begin send_frame(fa); send_frame(fb); end
      begin
        for (int k = 0; k < 7; k++) begin
          @(negedge clk);
          sr[k] = s_ready0; ml[k] = m_last0; fd[k] = frame_done0;
        end
      end
    join
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (sr[k] !== exp_sr[k]) begin n_fail++; $display("FAIL b2b_s_ready_c%0d: got %b, required %b", k, sr[k], exp_sr[k]); end
    end
    n_checks++; if (ml[5] !== 1'b1 || ml[4] !== 1'b0) begin n_fail++; $display("FAIL b2b_m_last: got %b%b, required 10", ml[5], ml[4]); end
    n_checks++; if (fd[6] !== 1'b1 || fd[5] !== 1'b0) begin n_fail++; $display("FAIL b2b_frame_done: got %b%b, required 10", fd[6], fd[5]); end
    wait_drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL b2b_beat%0d: got %h, required %h", k, o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL b2b_done_cnt: got %0d, required 2", done_cnt - d0); end
  endtask

  task automatic test_backpressure();
    logic [7:0]  fr[$];
    logic [17:0] e, o;
    int d0, s0;
    d0 = done_cnt;
    s0 = stall_err;
    bp_en = 1'b1;
    for (int f = 0; f < 8; f++) begin
      fr.delete();
      for (int i = 0; i < $urandom_range(1, 8); i++) fr.push_back(8'($urandom_range(0, 255)));
      send_frame(fr);
    end
    bp_en = 1'b0;
    @(posedge clk);
    #2;
    m_ready = 1'b1;
    wait_drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL bp_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL bp_beat%0d: got %h, required %h", k, o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (stall_err - s0 !== 0) begin n_fail++; $display("FAIL bp_stall_stable: got %0d changes, required 0", stall_err - s0); end
    n_checks++; if (done_cnt - d0 !== 8) begin n_fail++; $display("FAIL bp_done_cnt: got %0d, required 8", done_cnt - d0); end
    n_checks++; if (crc_result1 !== last_crc1) begin n_fail++; $display("FAIL bp_crc: got %h, required %h", crc_result1, last_crc1); end
  endtask

  task automatic test_reset_mid_frame();
    logic [7:0]  fr[$];
    logic [17:0] e, o;
    logic [15:0] hi_ref;
    int d0;
    m_ready = 1'b1;
    // Three payload bytes of an unterminated frame, then async reset.
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_data = 8'(8'h70 + i); s_last = 1'b0;
      @(posedge clk);
      #1;
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (m_valid0 !== 1'b0 || m_data0 !== 8'h00) begin n_fail++; $display("FAIL rmp_outputs: got v=%b d=%h, required v=0 d=00", m_valid0, m_data0); end
    n_checks++; if (s_ready0 !== 1'b0) begin n_fail++; $display("FAIL rmp_s_ready: got %b, required 0", s_ready0); end
    s_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    obs_q.delete();
    // Single-byte frame stalled in CRC_LO, then reset.
    s_valid = 1'b1; s_data = 8'hA5; s_last = 1'b1;
    @(posedge clk);
    #1;
    s_valid = 1'b0; s_last = 1'b0;
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    @(posedge clk);
    #1;
    hi_ref = ref_step(16'h0000, 8'hA5) ^ XO;
    n_checks++; if (m_valid0 !== 1'b1 || m_data0 !== hi_ref[15:8]) begin n_fail++; $display("FAIL rml_crc_hi: got v=%b d=%h, required v=1 d=%h", m_valid0, m_data0, hi_ref[15:8]); end
    d0 = done_cnt;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (m_valid0 !== 1'b0 || m_last0 !== 1'b0) begin n_fail++; $display("FAIL rml_outputs: got v=%b l=%b, required 0 0", m_valid0, m_last0); end
    n_checks++; if (crc_result0 !== 16'h0000) begin n_fail++; $display("FAIL rml_crc_result: got %h, required 0000", crc_result0); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_ready = 1'b1;
    obs_q.delete();
    for (int i = 0; i < 9; i++) fr.push_back(8'(8'h31 + i));
    send_frame(fr);
    wait_drain();
    n_checks++;
    if (obs_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rst_next_count: got %0d beats, required %0d", obs_q.size(), exp_q.size()); end
    for (int k = 0; exp_q.size() > 0 && obs_q.size() > 0; k++) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); n_checks++;
      if (o !== e) begin n_fail++; $display("FAIL rst_next_beat%0d: got %h, required %h", k, o, e); end
    end
    exp_q.delete(); obs_q.delete();
    n_checks++; if (crc_result0 !== KV0 || crc_result1 !== KV1) begin n_fail++; $display("FAIL rst_next_crc: got %h/%h, required %h/%h", crc_result0, crc_result1, KV0, KV1); end
    n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL rst_next_done: got %0d, required 1", done_cnt - d0); end
  endtask

  initial begin
    reset   = 1'b1;
    m_ready = 1'b1;
    s_valid = 1'b0;
    s_data  = 8'h00;
    s_last  = 1'b0;
    test_reset();
    test_known_vector();
    test_single_byte();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
